// File: rtl/feat_pkg.sv
// Shared types and constants for the feature-frame producer.
// Consumers see frames as NUM_FEATS signed FEAT_W-bit coefficients.
package feat_pkg;

  localparam int NUM_FEATS = 26;
  localparam int FEAT_W    = 16;

  typedef logic signed [FEAT_W-1:0] feat_t;
  typedef feat_t [NUM_FEATS-1:0]    feat_frame_t;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } fb_state_t;

endpackage

// File: rtl/feat_clip.sv
// Combinational saturator: limits a signed coefficient to
// [-CLIP_LIMIT, +CLIP_LIMIT]. Only instantiated when FEATURE_CLIP_EN is set.
module feat_clip #(
  parameter int                       FEAT_W     = feat_pkg::FEAT_W,
  parameter logic signed [FEAT_W-1:0] CLIP_LIMIT = 16'sd16383
) (
  input  logic signed [FEAT_W-1:0] coef_i,
  output logic signed [FEAT_W-1:0] coef_o
);

  localparam logic signed [FEAT_W-1:0] NEG_LIMIT = -CLIP_LIMIT;

  // Saturate to the symmetric limit, pass everything else through.
  always_comb begin
    if (coef_i > CLIP_LIMIT)     coef_o = CLIP_LIMIT;
    else if (coef_i < NEG_LIMIT) coef_o = NEG_LIMIT;
    else                         coef_o = coef_i;
  end

endmodule

// File: rtl/feature_frame_builder.sv
// Assembles a serial stream of signed coefficients into a NUM_FEATS-wide
// frame and hands it to the classifier over valid/ready. A fill buffer
// collects the next frame while the output register holds the current one.
// Optional: define FEATURE_CLIP_EN to saturate every accepted coefficient
// to +/-CLIP_LIMIT before it is stored.
module feature_frame_builder #(
  parameter int                       NUM_FEATS  = feat_pkg::NUM_FEATS,
  parameter int                       FEAT_W     = feat_pkg::FEAT_W,
  parameter logic signed [FEAT_W-1:0] CLIP_LIMIT = 16'sd16383
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [FEAT_W-1:0]          coef_in,
  input  logic                              coef_valid,
  input  logic                              coef_last,
  output logic                              coef_ready,
  output logic [NUM_FEATS-1:0][FEAT_W-1:0]  features,
  output logic                              frame_valid,
  input  logic                              frame_ready,
  output logic                              frame_err
);

  import feat_pkg::*;

  localparam int                IDX_W    = $clog2(NUM_FEATS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEATS - 1);

  fb_state_t                        state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_FEATS-1:0][FEAT_W-1:0] fill_q, fill_d;
  logic [NUM_FEATS-1:0][FEAT_W-1:0] feat_q, feat_d;
  logic                             valid_q, valid_d;
  logic                             err_q, err_d;

  logic signed [FEAT_W-1:0] coef_store;
  logic accept, at_end, complete, handshake, out_free;

`ifdef FEATURE_CLIP_EN
  feat_clip #(
    .FEAT_W     (FEAT_W),
    .CLIP_LIMIT (CLIP_LIMIT)
  ) u_clip (
    .coef_i (coef_in),
    .coef_o (coef_store)
  );
`else
  assign coef_store = coef_in;
  // Limit is only meaningful with clipping; park it so it is visibly unused.
  logic [FEAT_W-1:0] unused_clip_limit;
  assign unused_clip_limit = CLIP_LIMIT;
`endif

  assign coef_ready = (state_q == FILL);
  assign accept     = coef_valid && coef_ready;
  assign at_end     = (idx_q == LAST_IDX);
  assign complete   = accept && coef_last && at_end;
  assign handshake  = valid_q && frame_ready;
  assign out_free   = !valid_q || frame_ready;

  // Fill buffer with the coefficient being accepted this cycle merged in,
  // so a completing frame can be copied out without an extra cycle.
  always_comb begin
    fill_d         = fill_q;
    fill_d[idx_q]  = coef_store;
  end

  // Next-state logic for the control FSM, fill index and output register.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    feat_d  = feat_q;
    valid_d = valid_q;
    // A framing error is coef_last disagreeing with the position in the frame.
    err_d   = accept && (coef_last != at_end);

    if (handshake) valid_d = 1'b0;

    if (accept) idx_d = (coef_last || at_end) ? '0 : idx_q + IDX_W'(1);

    case (state_q)
      FILL: begin
        if (complete) begin
          if (out_free) begin
            feat_d  = fill_d;
            valid_d = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (handshake) begin
          feat_d  = fill_q;
          valid_d = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Fill buffer storage; written on every accepted coefficient.
  // NOTE: no reset here on purpose. A frame only leaves this buffer after all
  // NUM_FEATS slots were rewritten since the index last returned to 0, so the
  // power-up contents can never be observed.
  always_ff @(posedge clk) begin
    if (accept) fill_q <= fill_d;
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      feat_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      feat_q  <= feat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign features    = feat_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule
